// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one signed divider between NREQ requesters:
// grants and captures operands, pulses div_start, and routes the result or an error back to the owner.
module div_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_z,
    output logic [1:0]        rsp_err,
    output logic              div_start,
    output logic [W-1:0]      div_x,
    output logic [W-1:0]      div_y,
    input  logic [2*W-1:0]    div_z,
    input  logic              div_valid
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {ERR_OK, ERR_DIV0, ERR_OVF, ERR_TMO} err_t;

    state_t          state, state_d;
    logic [PW-1:0]   rr, rr_d;
    logic [PW-1:0]   owner, owner_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            valid_q;

    logic [NREQ-1:0] gnt_d, rsp_valid_d;
    logic [2*W-1:0]  rsp_z_d;
    logic [1:0]      rsp_err_d;
    logic            div_start_d;
    logic [W-1:0]    div_x_d, div_y_d;

    logic            any_req;
    logic [PW-1:0]   win;
    logic [W-1:0]    sel_x, sel_y;
    logic            y_zero, ovf, done, tmo;

    // Winner is the first set req bit scanning upward from rr, wrapping at NREQ.
    always_comb begin
        int idx;
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win     = PW'(idx);
            end
        end
    end

    assign sel_x  = req_x[int'(win)*W +: W];
    assign sel_y  = req_y[int'(win)*W +: W];
    assign y_zero = (sel_y == '0);
    assign ovf    = (sel_x == {1'b1, {(W-1){1'b0}}}) && (sel_y == '1);
    // A level already high from a previous op is not a completion; only a rising edge is.
    assign done   = div_valid && !valid_q;
    assign tmo    = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (any_req) state_d = (y_zero || ovf) ? RESP : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done || tmo) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every output is given a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_d       = '0;
        rsp_valid_d = '0;
        div_start_d = 1'b0;
        rsp_z_d     = rsp_z;
        rsp_err_d   = rsp_err;
        div_x_d     = div_x;
        div_y_d     = div_y;
        owner_d     = owner;
        rr_d        = rr;
        cnt_d       = cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = NREQ'(1) << win;
                    div_x_d = sel_x;
                    div_y_d = sel_y;
                    owner_d = win;
                    rr_d    = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
                    if (y_zero || ovf) begin
                        // Error paths answer immediately; gnt and rsp_valid share the cycle.
                        rsp_valid_d = NREQ'(1) << win;
                        rsp_z_d     = '0;
                        rsp_err_d   = y_zero ? ERR_DIV0 : ERR_OVF;
                    end else begin
                        div_start_d = 1'b1;
                    end
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                if (done) begin
                    rsp_valid_d = NREQ'(1) << owner;
                    rsp_z_d     = div_z;
                    rsp_err_d   = ERR_OK;
                end else if (tmo) begin
                    rsp_valid_d = NREQ'(1) << owner;
                    rsp_z_d     = '0;
                    rsp_err_d   = ERR_TMO;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            owner     <= '0;
            cnt       <= '0;
            valid_q   <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_z     <= '0;
            rsp_err   <= '0;
            div_start <= 1'b0;
            div_x     <= '0;
            div_y     <= '0;
        end else begin
            state     <= state_d;
            rr        <= rr_d;
            owner     <= owner_d;
            cnt       <= cnt_d;
            valid_q   <= div_valid;
            gnt       <= gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_z     <= rsp_z_d;
            rsp_err   <= rsp_err_d;
            div_start <= div_start_d;
            div_x     <= div_x_d;
            div_y     <= div_y_d;
        end
    end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one signed restoring/Booth divider (start/valid handshake, W-bit signed operands X/Y, 2W-bit result Z) between NREQ requesters.
- Round-robin arbitration, operand capture, and issue of a one-cycle start pulse.
- Detects completion by the rising edge of the divider's valid.
- Returns the result to the granted requester, with error codes for divide-by-zero, overflow and timeout.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, operand width in bits (signed two's complement)
TIMEOUT, 64, maximum cycles waited in WAIT before a timeout error is declared

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level; held with operands until gnt
req_x  input  NREQ*W  packed dividends, requester i at [i*W +: W]
req_y  input  NREQ*W  packed divisors, same packing
gnt  output  NREQ  one-hot, one-cycle pulse: operands of requester i captured
rsp_valid  output  NREQ  one-hot, one-cycle pulse: response for requester i
rsp_z  output  2W  result, valid only while any rsp_valid bit is high
rsp_err  output  2  00 ok, 01 divide-by-zero, 10 overflow, 11 timeout
div_start  output  1  one-cycle start pulse to divider
div_x  output  W  captured dividend to divider
div_y  output  W  captured divisor to divider
div_z  input  2W  divider result
div_valid  input  1  divider done flag

Behaviour:
- All outputs are registered. Reset values:
  - gnt, rsp_valid, rsp_z, rsp_err, div_start, div_x, div_y = 0.
  - state = IDLE, rr pointer = 0, timeout counter = 0, valid_q = 0.
- Reset is asynchronous. Asserting rst mid-operation immediately forces the reset values, including dropping div_start. Any in-flight result is discarded and no response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- Only one operation is outstanding at a time. Requests are sampled only in IDLE.
- IDLE, at a clock edge with any req bit high:
  - Select winner i: the first set bit scanning upward from rr pointer, with wrap-around.
  - Capture div_x = req_x[i], div_y = req_y[i] and the owner index. Set gnt[i] = 1 for the next cycle. Set rr pointer = (i+1) mod NREQ.
  - If y == 0: go to RESP, err 01, z = 0.
  - Else if x == -2^(W-1) and y == -1: go to RESP, err 10, z = 0.
  - Else: go to ISSUE.
  - On both error paths the divider is never started. gnt and rsp_valid are high in the same cycle.
- ISSUE: div_start = 1 for exactly this cycle; gnt[i] is also high this cycle. Clear the timeout counter, then go to WAIT.
- WAIT:
  - valid_q registers div_valid every cycle.
  - Completion is div_valid == 1 while valid_q == 0, i.e. a rising edge. A level that is already high (stale from a previous operation) is ignored.
  - On completion: capture div_z into rsp_z, err 00, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without completion: go to RESP, err 11, z = 0.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP: rsp_valid[owner] = 1 for exactly this cycle, with rsp_z/rsp_err valid. Next state is IDLE.
- A req still high in IDLE after RESP is treated as a new request.
- div_x/div_y hold their captured values from capture until the next capture.
- Requesters must not change operands while req is high and gnt has not yet been seen. A req dropped before gnt is simply not served.
- Latency on the ok path: req sampled at edge E0; gnt and div_start high in cycle E0+1; response one cycle after the divider's valid rising edge is sampled.
- Minimum idle-to-idle turnaround is 2 cycles (error path). No request is lost while the block is busy; requesters keep req high.

Test Plan:
1. After reset, req[0]=1 with x=7, y=2 and a divider model completing after 8 cycles:
   - gnt[0] and div_start pulse one cycle after the request, with div_x=7, div_y=2.
   - rsp_valid[0] pulses with rsp_z = model result (rem 1, quot 3), rsp_err=00.
2. req = 4'b1111 held continuously, with operands 7/6, 5/2, 6/3, 7/1: grants arrive in order 0,1,2,3,0. Each rsp_valid matches the owner and its result.
3. req[2]=1 with y=0: gnt[2] and rsp_valid[2] in the same cycle, rsp_err=01, rsp_z=0, div_start never asserts. A second case, x=-8 and y=-1, returns rsp_err=10.
4. A divider model that never raises valid, with div_valid stuck high from the previous op: the stale level is ignored. After TIMEOUT cycles, rsp_err=11 and rsp_z=0, then the block returns to IDLE.
5. Assert rst during WAIT: all outputs drop to 0 asynchronously with no rsp_valid. A subsequent req[1] is granted first (pointer reset to 0, scan finds 1).
6. div_valid rising edge on the same cycle the counter hits TIMEOUT-1: rsp_err=00 with the divider result.
